// File: rtl/conversor_defs.sv
// Shared definitions for the parallel-in/serial-out converter.
//   state_t : FSM state encoding (IDLE, SHIFT, GAP)
//   clog2   : ceiling log2, never less than 1 so a counter is at least 1 bit wide
package conversor_defs;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/contador_bits.sv
// Parameterised up-counter with terminal-count flag.
//   clk    : clock, rising edge
//   clr_i  : synchronous active-high clear (block reset)
//   zero_i : synchronous load-to-zero
//   en_i   : count enable
//   cnt_o  : current count
//   tc_o   : high while cnt_o equals TC
module contador_bits #(
  parameter int           W  = 2,
  parameter logic [W-1:0] TC = '1
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         zero_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zero_i)    cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC);

endmodule

// File: rtl/conversor_ps.sv
// Parallel-in/serial-out converter feeding a downstream serial-to-parallel stage.
// A WIDTH-bit word is taken on a valid/ready handshake and shifted out one bit
// per clock, optionally followed by GAP idle cycles.
//   clk        : clock, rising edge
//   CLR        : synchronous active-high reset
//   din        : parallel word, sampled only on the handshake edge
//   load_valid : din valid
//   load_ready : block accepts a word this cycle (combinational)
//   D_out      : serial data bit (registered)
//   bit_valid  : D_out carries a data bit
//   first_bit  : first bit of a word on the line
//   word_done  : last bit of a word on the line
//   busy       : block in SHIFT or GAP
//
// state   | meaning
// IDLE    | nothing on the line, ready for a word
// SHIFT   | word bits on the line, bit counter = index of the current bit
// GAP     | idle spacing between words, gap counter = cycles spent
module conversor_ps
  import conversor_defs::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             D_out,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW       = clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_PRE  = CW'(WIDTH - 2);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
  localparam bit            NO_GAP   = (GAP == 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dout_q, dout_d;
  logic             bv_q, bv_d;
  logic             fb_q, fb_d;
  logic             wd_q, wd_d;
  logic             busy_q, busy_d;

  logic [CW-1:0]    bit_cnt;
  logic             bit_tc, bit_zero, bit_en;
  logic [3:0]       gap_cnt;
  logic             gap_tc, gap_zero, gap_en;
  logic             handshake;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Moves the next bit to be sent into the head position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  contador_bits #(.W(CW), .TC(BIT_LAST)) u_bit_cnt (
    .clk    (clk),
    .clr_i  (CLR),
    .zero_i (bit_zero),
    .en_i   (bit_en),
    .cnt_o  (bit_cnt),
    .tc_o   (bit_tc)
  );

  contador_bits #(.W(4), .TC(GAP_LAST)) u_gap_cnt (
    .clk    (clk),
    .clr_i  (CLR),
    .zero_i (gap_zero),
    .en_i   (gap_en),
    .cnt_o  (gap_cnt),
    .tc_o   (gap_tc)
  );

  assign load_ready = (state_q == S_IDLE)
                    | ((state_q == S_SHIFT) & bit_tc & NO_GAP)
                    | ((state_q == S_GAP) & (gap_cnt == GAP_LAST));

  assign handshake = load_valid & load_ready;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    dout_d   = 1'b0;
    bv_d     = 1'b0;
    fb_d     = 1'b0;
    wd_d     = 1'b0;
    bit_zero = 1'b0;
    bit_en   = 1'b0;
    gap_zero = 1'b0;
    gap_en   = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_SHIFT: begin
        if (!bit_tc) begin
          bit_en  = 1'b1;
          dout_d  = head_bit(shreg_q);
          shreg_d = advance(shreg_q);
          bv_d    = 1'b1;
          wd_d    = (bit_cnt == BIT_PRE);
        end else begin
          bit_zero = 1'b1;
          if (NO_GAP) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_GAP;
            gap_zero = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (!gap_tc) begin
          gap_en = 1'b1;
        end else begin
          gap_zero = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A handshake only happens in a ready slot, so it overrides the
    // end-of-word / end-of-gap decisions above and starts the next word.
    if (handshake) begin
      state_d  = S_SHIFT;
      shreg_d  = advance(din);
      dout_d   = head_bit(din);
      bv_d     = 1'b1;
      fb_d     = 1'b1;
      wd_d     = 1'b0;
      bit_zero = 1'b1;
      bit_en   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      dout_q  <= 1'b0;
      bv_q    <= 1'b0;
      fb_q    <= 1'b0;
      wd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      bv_q    <= bv_d;
      fb_q    <= fb_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
    end
  end

  assign D_out     = dout_q;
  assign bit_valid = bv_q;
  assign first_bit = fb_q;
  assign word_done = wd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conversor_ps.sv
// Bench for conversor_ps: two instances (A: MSB first, no gap; B: LSB first,
// gap of 2) checked cycle by cycle against a schedule-based reference model.
module tb_conversor_ps;

  localparam int W  = 4;
  localparam int NC = 4096;
  localparam int GAPS [2] = '{0, 2};
  localparam int MSBF [2] = '{1, 0};

  logic         clk = 1'b0;
  logic         CLR = 1'b0;
  logic [W-1:0] din_a = '0, din_b = '0;
  logic         lv_a = 1'b0, lv_b = 1'b0;
  logic         rdy_a, d_a, bv_a, fb_a, wd_a, busy_a;
  logic         rdy_b, d_b, bv_b, fb_b, wd_b, busy_b;

  // expected {busy, bit_valid, first_bit, word_done, D_out} after each edge
  logic [4:0] exp_q [2][NC];
  int         free_from [2];
  int         edge_n = 0;
  bit         primed = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  conversor_ps #(.WIDTH(W), .MSB_FIRST(1), .GAP(0)) dut_a (
    .clk(clk), .CLR(CLR), .din(din_a), .load_valid(lv_a), .load_ready(rdy_a),
    .D_out(d_a), .bit_valid(bv_a), .first_bit(fb_a), .word_done(wd_a), .busy(busy_a)
  );

  conversor_ps #(.WIDTH(W), .MSB_FIRST(0), .GAP(2)) dut_b (
    .clk(clk), .CLR(CLR), .din(din_b), .load_valid(lv_b), .load_ready(rdy_b),
    .D_out(d_b), .bit_valid(bv_b), .first_bit(fb_b), .word_done(wd_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, edge_n, obs, expv);
    end
  endtask

  // A word accepted at edge n occupies the line after edges n..n+W-1, then
  // GAP idle-but-busy cycles; the next word can be taken at edge n+W+GAP.
  task automatic schedule(input int u, input logic [W-1:0] w, input int n);
    logic b;
    for (int k = 0; k < W; k++) begin
      b = (MSBF[u] != 0) ? w[W-1-k] : w[k];
      exp_q[u][n+k] = {1'b1, 1'b1, (k == 0), (k == W-1), b};
    end
    for (int g = 1; g <= GAPS[u]; g++) exp_q[u][n+W-1+g] = 5'b10000;
    free_from[u] = n + W + GAPS[u];
  endtask

  task automatic tick();
    logic         rdy_e;
    logic         rdy_o, lv_o;
    logic [W-1:0] din_o;
    logic [4:0]   obs;
    #1;
    for (int u = 0; u < 2; u++) begin
      rdy_e = (edge_n >= free_from[u]);
      rdy_o = (u == 0) ? rdy_a : rdy_b;
      lv_o  = (u == 0) ? lv_a : lv_b;
      din_o = (u == 0) ? din_a : din_b;
      if (primed) chk((u == 0) ? "A_load_ready" : "B_load_ready", {4'b0, rdy_o}, {4'b0, rdy_e});
      if (CLR) begin
        for (int k = 0; k < 16; k++) exp_q[u][edge_n+k] = '0;
        free_from[u] = edge_n + 1;
      end else if (lv_o && rdy_e) begin
        schedule(u, din_o, edge_n);
      end
    end
    @(posedge clk);
    #1;
    obs = {busy_a, bv_a, fb_a, wd_a, d_a};
    chk("A_outputs", obs, exp_q[0][edge_n]);
    obs = {busy_b, bv_b, fb_b, wd_b, d_b};
    chk("B_outputs", obs, exp_q[1][edge_n]);
    edge_n++;
    primed = 1'b1;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      free_from[u] = 0;
      for (int i = 0; i < NC; i++) exp_q[u][i] = '0;
    end

    // reset for two cycles, then idle
    CLR = 1'b1; tick(); tick();
    CLR = 1'b0; tick(); tick();

    // single word, MSB first
    din_a = 4'b1010; lv_a = 1'b1; tick();
    lv_a = 1'b0; din_a = 4'b0000;
    repeat (5) tick();

    // back-to-back with load_valid held, no gap
    din_a = 4'b1010; lv_a = 1'b1; tick();
    din_a = 4'b0110;
    repeat (4) tick();
    lv_a = 1'b0;
    repeat (5) tick();

    // gap of 2, LSB first, same word twice with valid held
    din_b = 4'b0011; lv_b = 1'b1; tick();
    repeat (6) tick();
    lv_b = 1'b0;
    repeat (8) tick();

    // load attempt during the 2nd bit is ignored
    din_a = 4'b1000; lv_a = 1'b1; tick();
    lv_a = 1'b0; tick();
    din_a = 4'b1111; lv_a = 1'b1; tick();
    lv_a = 1'b0; din_a = 4'b0000;
    repeat (4) tick();

    // reset during the 3rd bit, then a fresh word goes out intact
    din_a = 4'b1101; lv_a = 1'b1; tick();
    lv_a = 1'b0; tick(); tick();
    CLR = 1'b1; tick();
    CLR = 1'b0; tick();
    din_a = 4'b0101; lv_a = 1'b1; tick();
    lv_a = 1'b0;
    repeat (5) tick();

    // reset together with a handshake: word dropped
    CLR = 1'b1; din_a = 4'b1111; lv_a = 1'b1; din_b = 4'b1111; lv_b = 1'b1; tick();
    CLR = 1'b0; lv_a = 1'b0; lv_b = 1'b0; tick(); tick();

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      din_a = W'($urandom);
      din_b = W'($urandom);
      lv_a  = ($urandom_range(0, 3) != 0);
      lv_b  = ($urandom_range(0, 3) != 0);
      CLR   = ($urandom_range(0, 63) == 0);
      tick();
    end
    CLR = 1'b0; lv_a = 1'b0; lv_b = 1'b0;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conversor_ps.md
Name: conversor_ps

Overview:
Parallel-in/serial-out converter that feeds the serial-to-parallel stage's D input. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clk, MSB first by default. It marks the first bit of each word and pulses when the last bit is on the line. The downstream stage can then capture the complete word on the matching edge.

Parameters:
WIDTH, 4, word width in bits (≥2)
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
GAP, 0, idle cycles inserted between consecutive words (0..15)

Ports:
clk  input  1  system clock; all state changes on the rising edge
CLR  input  1  reset, synchronous and active-high
din  input  WIDTH  parallel word to transmit
load_valid  input  1  din is valid this cycle
load_ready  output  1  block can accept a word this cycle
D_out  output  1  serial data bit to the downstream D input
bit_valid  output  1  D_out carries a data bit this cycle
first_bit  output  1  high with the first bit of each word
word_done  output  1  high with the last bit of each word
busy  output  1  high in SHIFT or GAP

Behaviour:
- Reset:
  - CLR=1 at a rising edge forces state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - Outputs after that edge: D_out=0, bit_valid=0, first_bit=0, word_done=0, busy=0, load_ready=1.
  - CLR overrides everything, including mid-word: the word is abandoned and no further bits are emitted.
- Outputs are registered, except load_ready, which is combinational from state and counters.
- States and transitions:
  - IDLE -> SHIFT on handshake (load_valid & load_ready).
  - SHIFT -> SHIFT while count < WIDTH-1.
  - At count = WIDTH-1 with GAP=0: SHIFT -> SHIFT if a new handshake occurs, else SHIFT -> IDLE.
  - At count = WIDTH-1 with GAP>0: SHIFT -> GAP.
  - GAP -> GAP while gap counter < GAP-1.
  - At the end of GAP: GAP -> SHIFT on handshake, else GAP -> IDLE.
- load_ready = IDLE | (SHIFT & count==WIDTH-1 & GAP==0) | (GAP & gapcnt==GAP-1).
- Latency: a handshake at edge N puts the first bit on D_out after edge N, with bit_valid=1 and first_bit=1. Bit k appears after edge N+k.
- word_done=1 together with bit WIDTH-1 of the sequence.
- din is sampled only at the handshake edge; later changes to din have no effect on the word in flight.
- load_valid while load_ready=0 is ignored (no queuing). The source must hold load_valid until it sees ready.
- Back-to-back transfer with GAP=0: the first bit of word 2 immediately follows the last bit of word 1, with bit_valid continuously high and no bubble.
- When bit_valid=0: D_out=0, first_bit=0, word_done=0.
- Width rules:
  - Bit counter width is clog2(WIDTH); the gap counter is 4 bits.
  - The counter wraps to 0 on reload and never exceeds WIDTH-1.
- Simultaneous CLR and handshake: CLR wins and the word is dropped.

Decomposition:
- Shared package/header `conversor_defs`: state encoding constants S_IDLE=2'd0, S_SHIFT=2'd1, S_GAP=2'd2, and a clog2 function.
- One natural sub-module, `contador_bits`: a parameterised up-counter with synchronous CLR, load-to-zero, enable and terminal-count flag. It is instantiated twice, once for bits and once for the gap.
- The FSM and shift register stay in the top module.

Test Plan:
- CLR=1 for 2 cycles, then 0 → D_out=0, bit_valid=0, busy=0, load_ready=1.
- Single word, MSB_FIRST=1, din=4'b1010 accepted at edge N → D_out=1,0,1,0 after edges N..N+3. first_bit high at N, word_done high at N+3, then IDLE with bit_valid=0.
- Back-to-back, GAP=0: 4'b1010 then 4'b0110 with load_valid held → 8 contiguous bits 1,0,1,0,0,1,1,0. load_ready=1 only in IDLE and during the 4th bit of each word.
- GAP=2, MSB_FIRST=0, din=4'b0011 twice → bits 1,1,0,0, then 2 cycles with bit_valid=0, then 1,1,0,0.
- load_valid pulsed with din=4'b1111 during the 2nd bit of word 4'b1000 → ignored; output stays 1,0,0,0.
- CLR asserted during the 3rd bit of 4'b1101 → next cycle D_out=0, bit_valid=0, load_ready=1. A new word 4'b0101 is then sent intact.
